etapa1_div: RTL and testbench

Iterative restoring-division core directly downstream of the divider's operand-capture stage (etapa0). It accepts the registered go/divisor/dividend triple from etapa0, checks for divide-by-zero and quotient overflow, and computes a 16-bit quotient and remainder from a 32-bit dividend and a 16-bit divisor. It retires PASOS quotient bits per clock. `listo` is returned upstream so etapa0's `goIn` can be gated while a division is in flight.

---
 rtl/div_pkg.sv | 9 +
 rtl/etapa1_div_if.sv | 21 ++
 rtl/paso_resta.sv | 21 ++
 rtl/etapa1_div.sv | 102 ++++++++++
 tb/tb_etapa1_div.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared divider constants and FSM encoding, used by every divider stage.
package div_pkg;
  localparam int DV_W  = 16;
  localparam int DD_W  = 32;
  localparam int Q_W   = 16;
  localparam int DD_HI = 16;

  typedef enum logic [1:0] {IDLE, CHECK, ITER} estado_t;
endpackage

// File: rtl/etapa1_div_if.sv
// Operand/result bundle between etapa0 and the iterative division core.
interface etapa1_div_if import div_pkg::*; #(
  parameter int AnchoDv = DV_W-1,
  parameter int AnchoDd = DD_W-1,
  parameter int AnchoQ  = Q_W-1
);
  logic             goIn;
  logic [AnchoDv:0] divisorIn;
  logic [AnchoDd:0] dividendIn;
  logic             listo;
  logic             doneOut;
  logic [AnchoQ:0]  quotientOut;
  logic [AnchoQ:0]  remainderOut;
  logic             divZero;
  logic             overflow;

  modport master (output goIn, divisorIn, dividendIn,
                  input  listo, doneOut, quotientOut, remainderOut, divZero, overflow);
  modport slave  (input  goIn, divisorIn, dividendIn,
                  output listo, doneOut, quotientOut, remainderOut, divZero, overflow);
endinterface

// File: rtl/paso_resta.sv
// One combinational restoring-division step: shift {R,Q} left, subtract divisor if it fits.
module paso_resta #(
  parameter int W = 16
) (
  input  logic [W:0]   rIn,
  input  logic [W-1:0] qIn,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rOut,
  output logic [W-1:0] qOut
);
  logic [W+1:0] ext;
  logic [W:0]   diff;
  logic         cabe;

  // Keep the top bit in the compare so the step stays correct even without the R<divisor invariant.
  assign ext  = {rIn, qIn[W-1]};
  assign cabe = ext >= {2'b00, divisor};
  assign diff = ext[W:0] - {1'b0, divisor};
  assign rOut = cabe ? diff : ext[W:0];
  assign qOut = {qIn[W-2:0], cabe};
endmodule

// File: rtl/etapa1_div.sv
// Iterative restoring divider: 32/16 -> 16-bit quotient/remainder, PASOS quotient bits per cycle.
module etapa1_div import div_pkg::*; #(
  parameter int PASOS   = 4,
  parameter int AnchoDv = DV_W-1,
  parameter int AnchoDd = DD_W-1,
  parameter int AnchoQ  = Q_W-1
) (
  input  logic         clk,
  input  logic         reset,
  etapa1_div_if.slave  bus
);
  localparam int CW = $clog2(Q_W) + 1;

  estado_t           estado;
  logic [AnchoDv:0]  dvReg;
  logic [AnchoDd:0]  ddReg;
  logic [AnchoQ+1:0] rReg;
  logic [AnchoQ:0]   qReg;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cntNext;

  logic [AnchoQ+1:0] rCh [PASOS+1];
  logic [AnchoQ:0]   qCh [PASOS+1];

  assign rCh[0] = rReg;
  assign qCh[0] = qReg;

  for (genvar i = 0; i < PASOS; i++) begin : gPaso
    paso_resta #(.W(AnchoQ+1)) uPaso (
      .rIn    (rCh[i]),
      .qIn    (qCh[i]),
      .divisor(dvReg),
      .rOut   (rCh[i+1]),
      .qOut   (qCh[i+1])
    );
  end

  assign cntNext  = cnt + CW'(PASOS);
  assign bus.listo = (estado == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado           <= IDLE;
      dvReg            <= '0;
      ddReg            <= '0;
      rReg             <= '0;
      qReg             <= '0;
      cnt              <= '0;
      bus.doneOut      <= 1'b0;
      bus.quotientOut  <= '0;
      bus.remainderOut <= '0;
      bus.divZero      <= 1'b0;
      bus.overflow     <= 1'b0;
    end else begin
      bus.doneOut <= 1'b0;
      case (estado)
        IDLE: if (bus.goIn) begin
          dvReg  <= bus.divisorIn;
          ddReg  <= bus.dividendIn;
          estado <= CHECK;
        end
        CHECK: begin
          if (dvReg == '0) begin
            bus.divZero      <= 1'b1;
            bus.overflow     <= 1'b0;
            bus.quotientOut  <= '1;
            bus.remainderOut <= '0;
            bus.doneOut      <= 1'b1;
            estado           <= IDLE;
          end else if (ddReg[AnchoDd:DD_HI] >= dvReg) begin
            // High half >= divisor means the quotient needs more than 16 bits.
            bus.divZero      <= 1'b0;
            bus.overflow     <= 1'b1;
            bus.quotientOut  <= '1;
            bus.remainderOut <= '0;
            bus.doneOut      <= 1'b1;
            estado           <= IDLE;
          end else begin
            rReg   <= {1'b0, ddReg[AnchoDd:DD_HI]};
            qReg   <= ddReg[DD_HI-1:0];
            cnt    <= '0;
            estado <= ITER;
          end
        end
        ITER: begin
          rReg <= rCh[PASOS];
          qReg <= qCh[PASOS];
          cnt  <= cntNext;
          if (cntNext == CW'(Q_W)) begin
            bus.quotientOut  <= qCh[PASOS];
            bus.remainderOut <= rCh[PASOS][AnchoQ:0];
            bus.divZero      <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.doneOut      <= 1'b1;
            estado           <= IDLE;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_etapa1_div.sv
// Self-checking bench: five cores (PASOS=1,2,4,8,16) against an arithmetic reference model.
module tb_etapa1_div;
  import div_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] goV = '0;
  logic [31:0] dd = '0;
  logic [15:0] dv = '0;

  logic [4:0]       doneV, listoV, dzV, ovV;
  logic [4:0][15:0] qV, rV;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : gDut
    etapa1_div_if busI ();
    assign busI.goIn       = goV[g];
    assign busI.divisorIn  = dv;
    assign busI.dividendIn = dd;
    assign doneV[g]  = busI.doneOut;
    assign listoV[g] = busI.listo;
    assign dzV[g]    = busI.divZero;
    assign ovV[g]    = busI.overflow;
    assign qV[g]     = busI.quotientOut;
    assign rV[g]     = busI.remainderOut;

    etapa1_div #(.PASOS(1 << g)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (busI)
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void refModel(input logic [31:0] a, input logic [15:0] b, input int p,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic dz, output logic ov, output int lat);
    logic [15:0] hi;
    hi = a[31:16];
    dz = 1'b0; ov = 1'b0;
    if (b == 16'd0) begin
      dz = 1'b1; q = 16'hFFFF; r = 16'd0; lat = 1;
    end else if (hi >= b) begin
      ov = 1'b1; q = 16'hFFFF; r = 16'd0; lat = 1;
    end else begin
      q = 16'(a / {16'd0, b});
      r = 16'(a % {16'd0, b});
      lat = 16 / p + 1;
    end
  endfunction

  // Launch one division on all five cores and check each against the model.
  task automatic runAll(input logic [31:0] a, input logic [15:0] b, input string tag);
    int seenAt [5];
    int nDone [5];
    logic [15:0] qs [5], rs [5];
    logic dzs [5], ovs [5];
    logic [15:0] eq, er;
    logic edz, eov;
    int elat;
    @(negedge clk);
    dd = a; dv = b; goV = '1;
    @(posedge clk);
    @(negedge clk);
    goV = '0;
    for (int i = 0; i < 5; i++) begin seenAt[i] = -1; nDone[i] = 0; end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) if (doneV[i]) begin
        nDone[i]++;
        if (seenAt[i] < 0) begin
          seenAt[i] = k;
          qs[i] = qV[i]; rs[i] = rV[i]; dzs[i] = dzV[i]; ovs[i] = ovV[i];
          chk($sformatf("%s P%0d listo@done", tag, 1 << i), 64'(listoV[i]), 64'd1);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      refModel(a, b, 1 << i, eq, er, edz, eov, elat);
      chk($sformatf("%s P%0d pulses", tag, 1 << i), 64'(nDone[i]), 64'd1);
      chk($sformatf("%s P%0d latency", tag, 1 << i), 64'(seenAt[i]), 64'(elat));
      chk($sformatf("%s P%0d quot", tag, 1 << i), 64'(qs[i]), 64'(eq));
      chk($sformatf("%s P%0d rem", tag, 1 << i), 64'(rs[i]), 64'(er));
      chk($sformatf("%s P%0d flags", tag, 1 << i), 64'({dzs[i], ovs[i]}), 64'({edz, eov}));
    end
  endtask

  initial begin
    logic [15:0] b, hi;
    int sel, d1, d2;
    logic [15:0] q1, r1, q2, r2;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst done", 64'(doneV), 64'd0);
    chk("rst listo", 64'(listoV), 64'h1F);
    chk("rst flags", 64'({dzV, ovV}), 64'd0);
    chk("rst q", 64'(qV), 64'd0);
    chk("rst r", 64'(rV), 64'd0);
    reset = 1'b1;

    runAll(32'd100, 16'd7, "basic");
    runAll(32'h0006_FFFF, 16'd7, "maxq");
    runAll(32'h0007_0000, 16'd7, "ovf");
    runAll(32'h1234_5678, 16'd0, "divz");

    // Busy rejection on the PASOS=4 core
    @(negedge clk);
    dd = 32'd100; dv = 16'd7; goV = 5'b00100;
    @(posedge clk); @(negedge clk);
    goV = '0;
    @(posedge clk); @(negedge clk);
    dd = 32'd5000; dv = 16'd3; goV = 5'b00100;
    @(posedge clk); @(negedge clk);
    goV = '0;
    d1 = -1; d2 = 0;
    for (int k = 3; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (doneV[2]) begin
        d2++;
        if (d1 < 0) begin d1 = k; q1 = qV[2]; r1 = rV[2]; end
      end
    end
    chk("busy latency", 64'(d1), 64'd5);
    chk("busy pulses", 64'(d2), 64'd1);
    chk("busy quot", 64'(q1), 64'd14);
    chk("busy rem", 64'(r1), 64'd2);

    // Back-to-back with goIn held high
    @(negedge clk);
    dd = 32'd1000; dv = 16'd3; goV = 5'b00100;
    @(posedge clk); @(negedge clk);
    dd = 32'd50000; dv = 16'd9;
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (doneV[2]) begin
        if (d1 < 0) begin
          d1 = k; q1 = qV[2]; r1 = rV[2];
          chk("b2b listo@done", 64'(listoV[2]), 64'd1);
        end else begin
          d2 = k; q2 = qV[2]; r2 = rV[2];
        end
      end
      if (k == 6) goV = '0;
    end
    chk("b2b first lat", 64'(d1), 64'd5);
    chk("b2b second lat", 64'(d2), 64'd11);
    chk("b2b first q", 64'(q1), 64'd333);
    chk("b2b first r", 64'(r1), 64'd1);
    chk("b2b second q", 64'(q2), 64'd5555);
    chk("b2b second r", 64'(r2), 64'd5);

    // Reset during ITER
    @(negedge clk);
    dd = 32'h0001_2345; dv = 16'h0F0F; goV = '1;
    @(posedge clk); @(negedge clk);
    goV = '0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    chk("abort listo", 64'(listoV), 64'h1F);
    chk("abort q", 64'(qV), 64'd0);
    chk("abort r", 64'(rV), 64'd0);
    chk("abort flags", 64'({dzV, ovV}), 64'd0);
    d2 = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (doneV != '0) d2++;
    end
    chk("abort no done", 64'(d2), 64'd0);
    runAll(32'd1000, 16'd3, "post-abort");

    // Corners
    runAll(32'h0000_FFFF, 16'd1, "dv1");
    runAll(32'h0000_1234, 16'd1, "dv1b");
    runAll(32'hFFFE_FFFF, 16'hFFFF, "dvmax");
    runAll(32'hFFFF_0000, 16'hFFFF, "dvmax ovf");

    // Random sweep
    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(0, 9));
      b = (sel == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      if (sel == 0)      hi = 16'($urandom);
      else if (sel == 1) hi = 16'($urandom_range(int'(b), 65535));
      else               hi = 16'($urandom % b);
      runAll({hi, 16'($urandom)}, b, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
